// File: rtl/seg_arb_pkg.sv
// Shared widths, state encoding and small index helpers for the display arbiter.
package seg_arb_pkg;
    localparam int NUM_SRC = 3;
    localparam int DATA_W  = 20;
    localparam int POINT_W = 6;
    localparam int CNT_W   = 26;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BLANK = 2'd2
    } state_t;

    function automatic logic [NUM_SRC-1:0] onehot(input logic [1:0] idx);
        case (idx)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic req_at(input logic [NUM_SRC-1:0] r, input logic [1:0] idx);
        case (idx)
            2'd0:    return r[0];
            2'd1:    return r[1];
            default: return r[2];
        endcase
    endfunction

    // Modulo-3 successor of a source index.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        case (idx)
            2'd0:    return 2'd1;
            2'd1:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction
endpackage

// File: rtl/seg_rr_pick.sv
// Combinational round-robin picker: searches last_owner+1, +2, then last_owner itself.
module seg_rr_pick
    import seg_arb_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [1:0]         last_owner,
    input  logic               excl_last,
    output logic [1:0]         winner,
    output logic               any
);
    logic [1:0] cand1;
    logic [1:0] cand2;

    assign cand1 = next_idx(last_owner);
    assign cand2 = next_idx(cand1);

    // With excl_last set, "any" means a source other than the current owner is waiting.
    always_comb begin
        winner = last_owner;
        any    = 1'b1;
        if (req_at(req, cand1))
            winner = cand1;
        else if (req_at(req, cand2))
            winner = cand2;
        else if (req_at(req, last_owner) && !excl_last)
            winner = last_owner;
        else
            any = 1'b0;
    end
endmodule

// File: rtl/seg_disp_arb.sv
// Round-robin owner of the shared 6-digit display with minimum dwell and blanking gap.
module seg_disp_arb
    import seg_arb_pkg::*;
#(
    parameter logic [CNT_W-1:0] DWELL_MAX = 26'd49_999_999,
    parameter logic [CNT_W-1:0] BLANK_MAX = 26'd2_499_999
)
(
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [NUM_SRC-1:0]  req,
    input  logic [DATA_W-1:0]   data0,
    input  logic [DATA_W-1:0]   data1,
    input  logic [DATA_W-1:0]   data2,
    input  logic [POINT_W-1:0]  point0,
    input  logic [POINT_W-1:0]  point1,
    input  logic [POINT_W-1:0]  point2,
    input  logic                sign0,
    input  logic                sign1,
    input  logic                sign2,
    output logic [NUM_SRC-1:0]  gnt,
    output logic [DATA_W-1:0]   data,
    output logic [POINT_W-1:0]  point,
    output logic                sign,
    output logic                seg_en
);
    localparam int BUN_W = DATA_W + POINT_W + 1;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [1:0]         last_owner, last_nx;
    logic [NUM_SRC-1:0] gnt_nx;
    logic [BUN_W-1:0]   bun_nx;
    logic               seg_en_nx;
    logic [BUN_W-1:0]   bun0, bun1, bun2;
    logic [1:0]         winner;
    logic               pick_any;

    assign bun0 = {sign0, point0, data0};
    assign bun1 = {sign1, point1, data1};
    assign bun2 = {sign2, point2, data2};

    function automatic logic [BUN_W-1:0] src_bundle(input logic [1:0] idx,
                                                    input logic [BUN_W-1:0] b0,
                                                    input logic [BUN_W-1:0] b1,
                                                    input logic [BUN_W-1:0] b2);
        case (idx)
            2'd0:    return b0;
            2'd1:    return b1;
            default: return b2;
        endcase
    endfunction

    seg_rr_pick u_pick (
        .req        (req),
        .last_owner (last_owner),
        .excl_last  (state == GRANT),
        .winner     (winner),
        .any        (pick_any)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state               <= IDLE;
            cnt                 <= '0;
            last_owner          <= 2'd2;
            gnt                 <= '0;
            {sign, point, data} <= '0;
            seg_en              <= 1'b0;
        end else begin
            state               <= state_nx;
            cnt                 <= cnt_nx;
            last_owner          <= last_nx;
            gnt                 <= gnt_nx;
            {sign, point, data} <= bun_nx;
            seg_en              <= seg_en_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        last_nx   = last_owner;
        gnt_nx    = '0;
        bun_nx    = '0;
        seg_en_nx = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (pick_any) begin
                    state_nx  = GRANT;
                    last_nx   = winner;
                    gnt_nx    = onehot(winner);
                    bun_nx    = src_bundle(winner, bun0, bun1, bun2);
                    seg_en_nx = 1'b1;
                end
            end
            GRANT: begin
                gnt_nx    = gnt;
                bun_nx    = src_bundle(last_owner, bun0, bun1, bun2);
                seg_en_nx = 1'b1;
                cnt_nx    = (cnt == DWELL_MAX) ? cnt : cnt + 26'd1;
                // Owner release always wins; pre-emption only once dwell has been served.
                if (!req_at(req, last_owner) || (cnt == DWELL_MAX && pick_any)) begin
                    state_nx  = BLANK;
                    gnt_nx    = '0;
                    bun_nx    = '0;
                    seg_en_nx = 1'b0;
                    cnt_nx    = '0;
                end
            end
            BLANK: begin
                cnt_nx = cnt + 26'd1;
                if (cnt == BLANK_MAX) begin
                    cnt_nx = '0;
                    if (pick_any) begin
                        state_nx  = GRANT;
                        last_nx   = winner;
                        gnt_nx    = onehot(winner);
                        bun_nx    = src_bundle(winner, bun0, bun1, bun2);
                        seg_en_nx = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end
endmodule

// File: doc/seg_disp_arb.md
Name: seg_disp_arb

Overview:
- Time-shares the single 6-digit 595 seven-segment display between three independent value sources (e.g. counter, sensor reading, status code).
- Each source raises a request. The block grants the display to one source at a time, round-robin, with a guaranteed minimum dwell per owner.
- A blanking gap is inserted on every ownership change to avoid ghosting.
- Sits between the data generators and seg_595_dynamic, driving its data/point/sign/seg_en inputs.

Parameters:
- DWELL_MAX, 26'd49_999_999: owner keeps the display at least DWELL_MAX+1 cycles before being pre-empted by another requester (1 s at 50 MHz).
- BLANK_MAX, 26'd2_499_999: blank gap lasts BLANK_MAX+1 cycles (50 ms).

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- req  in  3  per-source display request, level-sensitive.
- data0 / data1 / data2  in  20 each  BCD-range value per source (0..999_999).
- point0 / point1 / point2  in  6 each  decimal-point mask per source.
- sign0 / sign1 / sign2  in  1 each  negative sign per source.
- gnt  out  3  one-hot grant; all-zero when nobody owns the display.
- data  out  20  to seg_595_dynamic.
- point  out  6  to seg_595_dynamic.
- sign  out  1  to seg_595_dynamic.
- seg_en  out  1  display enable to seg_595_dynamic.

Behaviour:
- Reset values (asynchronous, on sys_rst_n low): state IDLE; gnt=0, data=0, point=0, sign=0, seg_en=0; cnt=0; last_owner=2, so source 0 wins first.
- All outputs are registered. One 26-bit counter cnt is shared between dwell and blank timing.
- Round-robin pick: winner is the first asserted req in the order last_owner+1, last_owner+2, last_owner (mod 3).
- IDLE:
  - Outputs are zero.
  - Any req high -> GRANT to the pick winner at the next edge: gnt one-hot, last_owner=winner, cnt=0, seg_en=1.
- GRANT:
  - Every cycle: data/point/sign <= owner's inputs (1-cycle latency, tracks live changes); seg_en=1.
  - cnt increments, saturating at DWELL_MAX.
  - Owner's req low -> BLANK next edge, regardless of cnt.
  - cnt==DWELL_MAX and any other source requesting -> BLANK next edge.
  - Otherwise stay; a lone owner keeps the display indefinitely.
  - Owner drop in the same cycle as dwell expiry -> BLANK (the single case).
- BLANK:
  - gnt=0, seg_en=0, data/point/sign=0; cnt cleared on entry, then increments.
  - At cnt==BLANK_MAX, evaluate req: any high -> GRANT to the pick winner (the previous owner may win again only if it is the sole requester); none -> IDLE.
  - req changes before the evaluation cycle are ignored.
- gnt is never multi-hot. gnt and seg_en change on the same edge.
- Reset asserted mid-GRANT or mid-BLANK clears everything immediately. The first grant after reset goes to source 0 if it requests.

Decomposition:
- Package seg_arb_pkg holds:
  - NUM_SRC=3, DATA_W=20, POINT_W=6, CNT_W=26.
  - State encoding IDLE=2'd0, GRANT=2'd1, BLANK=2'd2.
- Sub-module seg_rr_pick is combinational:
  - Inputs: req[2:0], last_owner[1:0], excl_last.
  - Outputs: winner[1:0], any.
  - excl_last=1 in GRANT is used to test "another requester pending".
- The top wraps the FSM, counter, and output mux.

Test Plan (DWELL_MAX=9, BLANK_MAX=3):
- Reset, then req=3'b001 with data0=20'd123456, point0=6'b000100 -> next edge gnt=001, seg_en=1, data=123456, point=000100; holds with no timeout while req1/req2 stay low.
- req=3'b111 from IDLE -> grant order 0,1,2,0.
  - Each owner holds exactly 10 cycles of gnt.
  - 4-cycle gaps between owners with gnt=0, seg_en=0, data=0.
- Owner 0 drops req at GRANT cycle 3 -> BLANK next edge. After 4 cycles, with req=3'b010, gnt=010.
- Lone requester 2 releases, then re-requests during BLANK -> at the blank evaluation cycle, gnt=100 again. If no req is present at evaluation, the block goes to IDLE with all outputs 0.
- data1 changes 20'd5 -> 20'd6 while source 1 owns -> data output reflects 6 one cycle later.
- Assert sys_rst_n=0 mid-GRANT -> outputs 0 immediately (asynchronous). After release with req=3'b110, source 1 is granted first.
